// File: rtl/pipe_control_unit.sv
// MIPS pipeline control: opcode decode, ID/EX -> EX/MEM -> MEM/WB control
// registers, load-use stall, taken-branch flush and illegal-opcode counting.
module pipe_control_unit #(
    parameter int REG_W = 5,
    parameter int CNT_W = 8,
    parameter int OP_W  = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [OP_W-1:0]  opcode,
    input  logic [REG_W-1:0] if_id_rs,
    input  logic [REG_W-1:0] if_id_rt,
    input  logic [REG_W-1:0] id_ex_rt,
    input  logic             br_taken,
    output logic [3:0]       idex_ex,
    output logic [2:0]       idex_m,
    output logic [1:0]       idex_wb,
    output logic [2:0]       exmem_m,
    output logic [1:0]       exmem_wb,
    output logic [1:0]       memwb_wb,
    output logic             pc_write,
    output logic             if_id_write,
    output logic             if_flush,
    output logic             illegal_op,
    output logic [CNT_W-1:0] illegal_cnt
);

    localparam logic [OP_W-1:0] OP_RTYPE = OP_W'(6'b000000);
    localparam logic [OP_W-1:0] OP_LW    = OP_W'(6'b100011);
    localparam logic [OP_W-1:0] OP_SW    = OP_W'(6'b101011);
    localparam logic [OP_W-1:0] OP_BEQ   = OP_W'(6'b000100);
    localparam logic [OP_W-1:0] OP_ADDI  = OP_W'(6'b001000);

    logic [3:0] dec_ex;
    logic [2:0] dec_m;
    logic [1:0] dec_wb;
    logic       dec_illegal;
    logic       stall;

    logic [3:0]       idex_ex_q,  idex_ex_d;
    logic [2:0]       idex_m_q,   idex_m_d;
    logic [1:0]       idex_wb_q,  idex_wb_d;
    logic [2:0]       exmem_m_q,  exmem_m_d;
    logic [1:0]       exmem_wb_q, exmem_wb_d;
    logic [1:0]       memwb_wb_q, memwb_wb_d;
    logic             illegal_op_q, illegal_op_d;
    logic [CNT_W-1:0] illegal_cnt_q, illegal_cnt_d;

    always_comb begin
        dec_ex      = 4'b0000;
        dec_m       = 3'b000;
        dec_wb      = 2'b00;
        dec_illegal = 1'b0;
        case (opcode)
            OP_RTYPE: begin dec_ex = 4'b1100; dec_m = 3'b000; dec_wb = 2'b10; end
            OP_LW:    begin dec_ex = 4'b0001; dec_m = 3'b001; dec_wb = 2'b11; end
            OP_SW:    begin dec_ex = 4'b0001; dec_m = 3'b010; dec_wb = 2'b00; end
            OP_BEQ:   begin dec_ex = 4'b0010; dec_m = 3'b100; dec_wb = 2'b00; end
            OP_ADDI:  begin dec_ex = 4'b0001; dec_m = 3'b000; dec_wb = 2'b10; end
            default:  dec_illegal = 1'b1;
        endcase
    end

    // Register 0 is hardwired zero, so a load to it can never create a hazard.
    always_comb begin
        stall = idex_m_q[0] && (id_ex_rt != '0) &&
                ((id_ex_rt == if_id_rs) || (id_ex_rt == if_id_rt));
    end

    // A taken branch wins over a stall: the stalled instruction is being flushed anyway.
    always_comb begin
        pc_write    = br_taken || !stall;
        if_id_write = br_taken || !stall;
        if_flush    = br_taken;
    end

    always_comb begin
        idex_ex_d  = dec_ex;
        idex_m_d   = dec_m;
        idex_wb_d  = dec_wb;
        exmem_m_d  = idex_m_q;
        exmem_wb_d = idex_wb_q;
        memwb_wb_d = exmem_wb_q;
        if (br_taken || stall) begin
            idex_ex_d = '0;
            idex_m_d  = '0;
            idex_wb_d = '0;
        end
        if (br_taken) begin
            exmem_m_d  = '0;
            exmem_wb_d = '0;
        end
    end

    always_comb begin
        illegal_op_d  = illegal_op_q;
        illegal_cnt_d = illegal_cnt_q;
        if (dec_illegal && !stall && !br_taken) begin
            illegal_op_d = 1'b1;
            if (illegal_cnt_q != {CNT_W{1'b1}})
                illegal_cnt_d = illegal_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idex_ex_q     <= '0;
            idex_m_q      <= '0;
            idex_wb_q     <= '0;
            exmem_m_q     <= '0;
            exmem_wb_q    <= '0;
            memwb_wb_q    <= '0;
            illegal_op_q  <= 1'b0;
            illegal_cnt_q <= '0;
        end else begin
            idex_ex_q     <= idex_ex_d;
            idex_m_q      <= idex_m_d;
            idex_wb_q     <= idex_wb_d;
            exmem_m_q     <= exmem_m_d;
            exmem_wb_q    <= exmem_wb_d;
            memwb_wb_q    <= memwb_wb_d;
            illegal_op_q  <= illegal_op_d;
            illegal_cnt_q <= illegal_cnt_d;
        end
    end

    assign idex_ex     = idex_ex_q;
    assign idex_m      = idex_m_q;
    assign idex_wb     = idex_wb_q;
    assign exmem_m     = exmem_m_q;
    assign exmem_wb    = exmem_wb_q;
    assign memwb_wb    = memwb_wb_q;
    assign illegal_op  = illegal_op_q;
    assign illegal_cnt = illegal_cnt_q;

endmodule

// File: tb/tb_pipe_control_unit.sv
// Directed bench for pipe_control_unit: decode/latency, stall, flush,
// illegal counting (CNT_W=8 and a saturating CNT_W=2 copy), async reset.
module tb_pipe_control_unit;

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] opcode;
    logic [4:0] if_id_rs, if_id_rt, id_ex_rt;
    logic       br_taken;

    logic [3:0] idex_ex;
    logic [2:0] idex_m, exmem_m;
    logic [1:0] idex_wb, exmem_wb, memwb_wb;
    logic       pc_write, if_id_write, if_flush, illegal_op;
    logic [7:0] illegal_cnt;

    logic [3:0] s_idex_ex;
    logic [2:0] s_idex_m, s_exmem_m;
    logic [1:0] s_idex_wb, s_exmem_wb, s_memwb_wb;
    logic       s_pc_write, s_if_id_write, s_if_flush, s_illegal_op;
    logic [1:0] s_illegal_cnt;

    int checks = 0;
    int fails  = 0;

    always #5 clk = ~clk;

    pipe_control_unit #(.REG_W(5), .CNT_W(8), .OP_W(6)) u_dut (
        .clk(clk), .rst(rst), .opcode(opcode), .if_id_rs(if_id_rs),
        .if_id_rt(if_id_rt), .id_ex_rt(id_ex_rt), .br_taken(br_taken),
        .idex_ex(idex_ex), .idex_m(idex_m), .idex_wb(idex_wb),
        .exmem_m(exmem_m), .exmem_wb(exmem_wb), .memwb_wb(memwb_wb),
        .pc_write(pc_write), .if_id_write(if_id_write), .if_flush(if_flush),
        .illegal_op(illegal_op), .illegal_cnt(illegal_cnt)
    );

    pipe_control_unit #(.REG_W(5), .CNT_W(2), .OP_W(6)) u_sat (
        .clk(clk), .rst(rst), .opcode(opcode), .if_id_rs(if_id_rs),
        .if_id_rt(if_id_rt), .id_ex_rt(id_ex_rt), .br_taken(br_taken),
        .idex_ex(s_idex_ex), .idex_m(s_idex_m), .idex_wb(s_idex_wb),
        .exmem_m(s_exmem_m), .exmem_wb(s_exmem_wb), .memwb_wb(s_memwb_wb),
        .pc_write(s_pc_write), .if_id_write(s_if_id_write), .if_flush(s_if_flush),
        .illegal_op(s_illegal_op), .illegal_cnt(s_illegal_cnt)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [5:0] ops    [7];
    logic [3:0] exp_ex [7];
    logic [2:0] exp_m  [7];
    logic [1:0] exp_wb [7];

    initial begin
        ops    = '{6'h00, 6'h23, 6'h2B, 6'h04, 6'h08, 6'h00, 6'h00};
        exp_ex = '{4'hC, 4'h1, 4'h1, 4'h2, 4'h1, 4'hC, 4'hC};
        exp_m  = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd0, 3'd0, 3'd0};
        exp_wb = '{2'd2, 2'd3, 2'd0, 2'd0, 2'd2, 2'd2, 2'd2};

        rst = 1'b1; opcode = 6'h00; if_id_rs = '0; if_id_rt = '0;
        id_ex_rt = '0; br_taken = 1'b0;
        #12;
        check("rst_idex_ex", idex_ex, 0);
        check("rst_idex_m", idex_m, 0);
        check("rst_memwb", memwb_wb, 0);
        check("rst_pc_write", pc_write, 1);
        check("rst_ifid_write", if_id_write, 1);
        check("rst_cnt", illegal_cnt, 0);
        rst = 1'b0;
        tick();

        // decode and latency through the three control registers
        for (int i = 0; i < 7; i++) begin
            opcode = ops[i];
            tick();
            check($sformatf("dec_ex_%0d", i), idex_ex, exp_ex[i]);
            check($sformatf("dec_m_%0d", i), idex_m, exp_m[i]);
            check($sformatf("dec_wb_%0d", i), idex_wb, exp_wb[i]);
            if (i >= 1) begin
                check($sformatf("exmem_m_%0d", i), exmem_m, exp_m[i-1]);
                check($sformatf("exmem_wb_%0d", i), exmem_wb, exp_wb[i-1]);
            end
            if (i >= 2)
                check($sformatf("memwb_%0d", i), memwb_wb, exp_wb[i-2]);
        end

        // load-use stall on rs
        opcode = 6'h23; id_ex_rt = 5'd8;
        tick();
        opcode = 6'h00; if_id_rs = 5'd8;
        @(negedge clk);
        check("stall_pc_write", pc_write, 0);
        check("stall_ifid_write", if_id_write, 0);
        check("stall_flush", if_flush, 0);
        tick();
        check("bubble_ex", idex_ex, 0);
        check("bubble_m", idex_m, 0);
        check("bubble_wb", idex_wb, 0);
        check("bubble_exmem_m", exmem_m, 3'b001);
        check("bubble_exmem_wb", exmem_wb, 2'b11);
        check("post_stall_pc", pc_write, 1);
        tick();
        check("post_stall_ex", idex_ex, 4'hC);

        // load to register 0 never stalls
        opcode = 6'h23; id_ex_rt = 5'd0; if_id_rs = 5'd0;
        tick();
        opcode = 6'h00;
        @(negedge clk);
        check("r0_pc_write", pc_write, 1);
        check("r0_ifid_write", if_id_write, 1);
        tick();
        check("r0_ex", idex_ex, 4'hC);

        // taken branch flush
        opcode = 6'h04;
        tick();
        opcode = 6'h00;
        tick();
        check("br_exmem_m", exmem_m, 3'b100);
        opcode = 6'h08; br_taken = 1'b1;
        @(negedge clk);
        check("br_flush", if_flush, 1);
        check("br_pc_write", pc_write, 1);
        check("br_ifid_write", if_id_write, 1);
        tick();
        br_taken = 1'b0;
        check("br_idex_ex", idex_ex, 0);
        check("br_idex_wb", idex_wb, 0);
        check("br_exmem_m0", exmem_m, 0);
        check("br_exmem_wb0", exmem_wb, 0);
        check("br_memwb", memwb_wb, 0);

        // branch together with a load-use hazard on rt
        opcode = 6'h23; id_ex_rt = 5'd5;
        tick();
        opcode = 6'h00; if_id_rt = 5'd5; br_taken = 1'b1;
        @(negedge clk);
        check("brst_pc_write", pc_write, 1);
        check("brst_ifid_write", if_id_write, 1);
        check("brst_flush", if_flush, 1);
        tick();
        br_taken = 1'b0; if_id_rt = 5'd0;
        check("brst_idex_ex", idex_ex, 0);
        check("brst_idex_m", idex_m, 0);
        check("brst_exmem_m", exmem_m, 0);
        check("cnt_none", illegal_cnt, 0);
        check("flag_none", illegal_op, 0);

        // illegal opcode: one stalled cycle, then two counted
        opcode = 6'h23; id_ex_rt = 5'd9;
        tick();
        opcode = 6'h3F; if_id_rs = 5'd9;
        @(negedge clk);
        check("ill_stall_pc", pc_write, 0);
        tick();
        check("ill_stalled_cnt", illegal_cnt, 0);
        if_id_rs = 5'd0; id_ex_rt = 5'd0;
        tick();
        check("ill_cnt1", illegal_cnt, 1);
        tick();
        check("ill_cnt2", illegal_cnt, 2);
        check("ill_flag", illegal_op, 1);
        check("ill_dec_ex", idex_ex, 0);
        check("ill_dec_m", idex_m, 0);
        check("ill_dec_wb", idex_wb, 0);
        check("sat_cnt2", s_illegal_cnt, 2);
        repeat (3) tick();
        check("ill_cnt5", illegal_cnt, 5);
        check("sat_cnt3", s_illegal_cnt, 3);
        check("sat_flag", s_illegal_op, 1);
        br_taken = 1'b1;
        tick();
        br_taken = 1'b0;
        check("ill_flushed_cnt", illegal_cnt, 5);

        // asynchronous reset mid-stream
        opcode = 6'h00;
        repeat (3) tick();
        check("pre_rst_memwb", memwb_wb, 2'b10);
        #2;
        rst = 1'b1;
        #1;
        check("arst_idex_ex", idex_ex, 0);
        check("arst_idex_wb", idex_wb, 0);
        check("arst_exmem_wb", exmem_wb, 0);
        check("arst_memwb", memwb_wb, 0);
        check("arst_flag", illegal_op, 0);
        check("arst_cnt", illegal_cnt, 0);
        check("arst_pc_write", pc_write, 1);
        check("arst_ifid_write", if_id_write, 1);
        check("arst_flush", if_flush, 0);
        tick();
        rst = 1'b0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule

// File: doc/pipe_control_unit.md
Name: pipe_control_unit

Overview:
- Next-generation MIPS pipeline control block.
- Decodes the ID-stage opcode into EX/M/WB control bundles and carries them through the ID/EX, EX/MEM and MEM/WB control registers.
- Detects load-use hazards: stalls the PC and IF/ID and inserts a bubble.
- Flushes younger instructions on a taken branch.
- Counts illegal opcodes instead of only reporting them in simulation.

Parameters:
- REG_W, 5, register-specifier width (rs/rt compare width).
- CNT_W, 8, width of the saturating illegal-opcode counter.
- OP_W, 6, opcode width.

Ports:
- clk  in  1  system clock, all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- opcode  in  OP_W  opcode of instruction in IF/ID
- if_id_rs  in  REG_W  rs field of instruction in IF/ID
- if_id_rt  in  REG_W  rt field of instruction in IF/ID
- id_ex_rt  in  REG_W  rt (load destination) held in datapath ID/EX register
- br_taken  in  1  branch in EX/MEM resolved taken (datapath: exmem_m[2] & zero)
- idex_ex  out  4  {RegDst, ALUOp[1:0], ALUSrc} for EX stage
- idex_m  out  3  {Branch, MemWrite, MemRead} held in ID/EX
- idex_wb  out  2  {RegWrite, MemtoReg} held in ID/EX
- exmem_m  out  3  M bundle for MEM stage
- exmem_wb  out  2  WB bundle held in EX/MEM
- memwb_wb  out  2  WB bundle for WB stage
- pc_write  out  1  PC load enable (0 = hold)
- if_id_write  out  1  IF/ID load enable (0 = hold)
- if_flush  out  1  clear IF/ID on next edge
- illegal_op  out  1  sticky illegal-opcode flag
- illegal_cnt  out  CNT_W  saturating illegal-opcode count

Behaviour:
- Decode (combinational, no X outputs), EX/M/WB:
  - R-type 000000: 1100/000/10
  - LW 100011: 0001/001/11
  - SW 101011: 0001/010/00
  - BEQ 000100: 0010/100/00
  - ADDI 001000: 0001/000/10
  - any other opcode: illegal, all zeros.
- Control registers update on every rising clk edge: ID/EX <- decode, EX/MEM <- ID/EX M,WB, MEM/WB <- EX/MEM WB. Latency: decode to idex_* is 1 cycle, exmem_* is 2 cycles, memwb_wb is 3 cycles.
- Load-use stall (stall = 1):
  - Condition: idex_m[0] (MemRead) = 1, id_ex_rt != 0, and id_ex_rt equals if_id_rs or if_id_rt.
  - Combinational outputs: pc_write = 0, if_id_write = 0.
  - Next edge: ID/EX loads all-zero (bubble). EX/MEM and MEM/WB advance normally.
  - A stall lasts exactly one cycle, because the bubble clears MemRead.
- Branch flush:
  - if_flush = br_taken (combinational).
  - Next edge: ID/EX and EX/MEM load all-zero. MEM/WB advances from the current EX/MEM contents, so the branch itself completes.
  - pc_write = 1 and if_id_write = 1 while flushing.
- Priority: br_taken overrides stall. When both are asserted, flush behaviour applies and pc_write = 1.
- Otherwise pc_write = 1, if_id_write = 1, if_flush = 0.
- Illegal opcode handling:
  - Counted on an edge where the opcode is illegal, stall = 0 and br_taken = 0.
  - Each count sets illegal_op and increments illegal_cnt.
  - illegal_cnt saturates at 2^CNT_W-1.
  - illegal_op clears only on rst.
  - A stalled or flushed illegal opcode is not counted; a stalled one is counted when re-presented.
- Reset (asynchronous, mid-operation included): all control registers 0, illegal_op = 0, illegal_cnt = 0. Combinational outputs follow from the zeroed state: pc_write = 1, if_id_write = 1, if_flush = br_taken.
- Register 0 never triggers a stall.

Test Plan:
- Reset then apply R-type, LW, SW, BEQ, ADDI on consecutive cycles. Required: idex_ex/idex_m/idex_wb equal 1100/000/10, 0001/001/11, 0001/010/00, 0010/100/00, 0001/000/10 one cycle later. exmem_m follows one cycle after that; memwb_wb follows one cycle after exmem_m.
- LW with id_ex_rt = 8, then R-type with if_id_rs = 8. Required: pc_write = 0 and if_id_write = 0 for exactly one cycle, idex_* = 0 the next cycle, then normal flow. Repeat with id_ex_rt = 0: no stall.
- BEQ reaches EX/MEM and br_taken = 1 for one cycle. Required: if_flush = 1 that cycle; next cycle idex_* = 0 and exmem_* = 0; memwb_wb = 00 from BEQ.
- br_taken = 1 together with a load-use hazard. Required: pc_write = 1, if_flush = 1, ID/EX zero.
- Opcode 111111 for 3 cycles, one of them stalled. Required: illegal_cnt = 2, illegal_op = 1, decode all zeros. With CNT_W = 2, 5 illegal opcodes give illegal_cnt = 3.
- Assert rst mid-stream with nonzero pipeline and counter. Required: all outputs zero immediately (asynchronous) except pc_write = 1 and if_id_write = 1.
